uart_frame_sched: RTL and testbench
===================================

# uart_frame_sched

Frame scheduler for the UART transmit path of the 13-channel voltmeter. On a start request it reads every channel's 12-bit sample through a synchronous read port, formats each one as a 7-byte ASCII hex record, and writes the bytes into the UART transmit FIFO (`wr_uart`/`w_data`), honouring `tx_full` back-pressure. It sits between the sample store and the `uart` top and owns all sequencing of transmitted traffic.

## Interface
- `NCH`, default 13: number of channels per frame, 1..16.
- `AW`, default 4: channel address width, must satisfy 2^AW ≥ NCH.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: frame request pulse, sampled on the rising edge.
- `ch_addr` out AW: channel read address.
- `ch_data` in 12: sample at `ch_addr`, valid one cycle after the address is presented.
- `tx_full` in 1: UART TX FIFO full.
- `wr_uart` out 1: FIFO write strobe.
- `w_data` out 8: byte to write.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when the last byte of a frame has been written.

## Operation
- States and transitions:
  - IDLE: `start` → FETCH, with `ch_idx`=0.
  - FETCH: always → LATCH after 1 cycle.
  - LATCH: always → SEND. `ch_data` is captured into `val` at the edge that ends LATCH.
  - SEND: after byte 6 is written, go to DONE if `ch_idx`=NCH-1. Otherwise increment `ch_idx` and go to FETCH.
  - DONE: always → IDLE after 1 cycle.
- `ch_addr` = `ch_idx` (registered). It holds its value outside FETCH/LATCH.
- Record for channel i, in byte order:
  - byte 0: hex(i)
  - byte 1: ':' (0x3A)
  - bytes 2–4: hex(`val[11:8]`), hex(`val[7:4]`), hex(`val[3:0]`)
  - byte 5: CR (0x0D)
  - byte 6: LF (0x0A)
- hex(n) = 0x30+n for n<10, otherwise 0x41+n-10. Digits are uppercase.
- Frame = NCH×7 bytes, which is 91 at the default NCH.
- SEND behaviour:
  - `wr_uart` = ~`tx_full` (combinational from state and `tx_full`).
  - `w_data` = the current byte, selected by `byte_idx` (0..6).
  - `byte_idx` advances only on cycles where `wr_uart`=1. It wraps to 0 after byte 6.
- Back-pressure: while `tx_full`=1, `wr_uart`=0 and `byte_idx`, `val` and `w_data` are held. No byte is dropped or duplicated.
- `start` while `busy`=1 is ignored and is not queued.
- `start` in the DONE cycle is also ignored. `start` is accepted again from IDLE.
- `busy` = (state ≠ IDLE). `done` = (state = DONE).

## Timing
- Reset (asynchronous, immediate) returns:
  - state=IDLE, `ch_idx`=0, `byte_idx`=0, `val`=0
  - `ch_addr`=0, `wr_uart`=0, `w_data`=0x00, `busy`=0, `done`=0
- Reset mid-frame aborts the frame: no `done` pulse, and `wr_uart` drops immediately.
- `w_data` = 0x00 in every state other than SEND.
- Cycle numbering: the edge that samples `start` is edge 0, and cycle n follows edge n-1.
- Per-channel schedule: channel k occupies cycles 9k+1 (FETCH), 9k+2 (LATCH) and 9k+3..9k+9 (SEND), when `tx_full`=0.
- Minimum frame timing with `tx_full` never asserted:
  - first `wr_uart` in cycle 3
  - last `wr_uart` in cycle 9·NCH (117 at default)
  - `done` in cycle 9·NCH+1 (118)
  - `busy` high in cycles 1..118
- Each cycle of `tx_full`=1 during SEND adds exactly one cycle. FETCH and LATCH do not look at `tx_full`.
- `tx_full` is assumed to reflect writes made up to the previous edge; the FIFO's full flag is registered.

## Structure
- Package `uart_frame_pkg` holds:
  - the state enum (IDLE, FETCH, LATCH, SEND, DONE)
  - ASCII constants: COLON=0x3A, CR=0x0D, LF=0x0A
  - `BYTES_PER_REC`=7
- Sub-module `hex_to_ascii` is combinational: 4-bit nibble in, 8-bit ASCII out. It is used for the channel digit and the three value digits.
- `uart_frame_sched` is instantiated alongside `uart`:
  - its `wr_uart`/`w_data` drive the `uart` inputs
  - `uart`'s `tx_full` feeds back to it
  - both share `clk`/`rst`

## Test plan
- Reset with `start`=0: all outputs at their reset values; `busy` stays 0 for 20 cycles.
- Single frame, `ch_data[i]`=0x100·i+i (ch3=0x303, ch12=0xC0C), `tx_full`=0:
  - exactly 91 writes
  - channel 12 record = 0x43,0x3A,0x43,0x30,0x43,0x0D,0x0A
  - first write in cycle 3, `done` in cycle 118
- Hex edge values ch0=0x000, ch1=0xFFF, ch2=0xA09 → records "0:000\r\n", "1:FFF\r\n", "2:A09\r\n".
- `tx_full` held high for 5 cycles during byte 2 of ch4:
  - no writes during the hold
  - byte resumes unchanged
  - `done` delayed by exactly 5 cycles (cycle 123)
- `start` pulses at cycles 10 and 118: both ignored, no second frame. A `start` pulse at cycle 119 (IDLE) starts a new frame.
- `rst` asserted in cycle 50:
  - `wr_uart` and `busy` low the same cycle
  - no `done` pulse
  - a following `start` produces a complete 91-byte frame beginning with '0'.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and ASCII constants for the UART frame scheduler.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0]  COLON         = 8'h3A;
    localparam logic [7:0]  CR            = 8'h0D;
    localparam logic [7:0]  LF            = 8'h0A;
    localparam int unsigned BYTES_PER_REC = 7;
    localparam int unsigned BIDX_W        = 3;

endpackage

// File: rtl/uart_frame_sched_hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    // 'A' - 10 = 0x37
    assign ascii_o = (nib_i < 4'd10) ? (8'h30 + {4'h0, nib_i})
                                     : (8'h37 + {4'h0, nib_i});

endmodule

// File: rtl/uart_frame_sched.sv
// Frame scheduler: reads NCH 12-bit samples and streams "C:VVV\r\n" records
// into the UART TX FIFO, stalling on tx_full.
module uart_frame_sched
    import uart_frame_pkg::*;
#(
    parameter int unsigned NCH = 13,
    parameter int unsigned AW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] ch_addr,
    input  logic [11:0]   ch_data,
    input  logic          tx_full,
    output logic          wr_uart,
    output logic [7:0]    w_data,
    output logic          busy,
    output logic          done
);

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_REC - 1);
    localparam logic [AW-1:0]     LAST_CH   = AW'(NCH - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       ch_idx_q, ch_idx_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [11:0]         val_q, val_d;

    logic [3:0]          ch_nib;
    logic [7:0]          asc_ch, asc_v2, asc_v1, asc_v0;
    logic [7:0]          rec_byte;

    assign ch_nib = 4'(ch_idx_q);

    hex_to_ascii u_hex_ch (.nib_i(ch_nib),       .ascii_o(asc_ch));
    hex_to_ascii u_hex_v2 (.nib_i(val_q[11:8]),  .ascii_o(asc_v2));
    hex_to_ascii u_hex_v1 (.nib_i(val_q[7:4]),   .ascii_o(asc_v1));
    hex_to_ascii u_hex_v0 (.nib_i(val_q[3:0]),   .ascii_o(asc_v0));

    always_comb begin
        rec_byte = '0;
        case (byte_idx_q)
            3'd0:    rec_byte = asc_ch;
            3'd1:    rec_byte = COLON;
            3'd2:    rec_byte = asc_v2;
            3'd3:    rec_byte = asc_v1;
            3'd4:    rec_byte = asc_v0;
            3'd5:    rec_byte = CR;
            3'd6:    rec_byte = LF;
            default: rec_byte = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_idx_q   <= '0;
            byte_idx_q <= '0;
            val_q      <= '0;
        end else begin
            state_q    <= state_d;
            ch_idx_q   <= ch_idx_d;
            byte_idx_q <= byte_idx_d;
            val_q      <= val_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_idx_d   = ch_idx_q;
        byte_idx_d = byte_idx_q;
        val_d      = val_q;
        wr_uart    = 1'b0;
        w_data     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FETCH;
                    ch_idx_d = '0;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                // Sample store returns data one cycle after the address.
                val_d   = ch_data;
                state_d = SEND;
            end
            SEND: begin
                wr_uart = ~tx_full;
                w_data  = rec_byte;
                if (!tx_full) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        if (ch_idx_q == LAST_CH) begin
                            state_d = DONE;
                        end else begin
                            ch_idx_d = ch_idx_q + 1'b1;
                            state_d  = FETCH;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ch_addr = ch_idx_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched with a byte scoreboard queue.
module tb_uart_frame_sched;

    localparam int NCH = 13;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] ch_addr;
    logic [11:0]   ch_data;
    logic          tx_full;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic          busy;
    logic          done;

    logic [11:0]   mem [0:15];
    logic [7:0]    cap [0:255];
    logic [7:0]    exp_q[$];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ch_data <= mem[ch_addr];

    uart_frame_sched #(.NCH(NCH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ch_addr (ch_addr),
        .ch_data (ch_data),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    // Runs one frame; cycle n is the cycle after edge n-1, edge 0 samples start.
    task automatic run_frame(input int hold_at, input int hold_len, input int s1, input int s2,
                             input int rst_at, output int first_wr, output int last_wr,
                             output int done_cyc, output int nwr);
        int  n;
        int  held;
        bit  fin;
        first_wr = -1; last_wr = -1; done_cyc = -1; nwr = 0; held = 0; fin = 0;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back(hexc(4'(c)));
            exp_q.push_back(8'h3A);
            exp_q.push_back(hexc(mem[c][11:8]));
            exp_q.push_back(hexc(mem[c][7:4]));
            exp_q.push_back(hexc(mem[c][3:0]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 1;
        while (!fin && n < 400) begin
            start   = (n == s1 || n == s2);
            tx_full = (hold_len > 0 && nwr == hold_at && held < hold_len);
            if (tx_full) held++;
            if (n == rst_at) rst = 1'b1;
            @(negedge clk);
            if (n == rst_at) begin
                checks++;
                if (wr_uart !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                    w_data !== 8'h00 || ch_addr !== '0) begin
                    errors++;
                    $display("FAIL mid_reset: wr=%b busy=%b done=%b wd=%h addr=%h, want 0 0 0 00 0",
                             wr_uart, busy, done, w_data, ch_addr);
                end
                fin = 1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy cyc%0d: got %b want 1", n, busy);
                end
                if (tx_full && exp_q.size() > 0) begin
                    checks++;
                    if (wr_uart !== 1'b0 || w_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL hold cyc%0d: wr=%b wd=%h, want wr=0 wd=%h", n, wr_uart, w_data, exp_q[0]);
                    end
                end
                if (wr_uart === 1'b1) begin
                    if (first_wr < 0) first_wr = n;
                    last_wr = n;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_write cyc%0d: got %h, want no write", n, w_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (w_data !== e) begin
                            errors++;
                            $display("FAIL byte%0d cyc%0d: got %h want %h", nwr, n, w_data, e);
                        end
                    end
                    if (nwr < 256) cap[nwr] = w_data;
                    nwr++;
                end
                if (done === 1'b1) begin
                    done_cyc = n;
                    fin = 1;
                end
            end
            if (!fin) begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL timeout: got no done within 400 cycles, want done");
        end
        tx_full = 1'b0;
        if (start) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic check_timing(input string nm, input int fw, input int lw, input int dc, input int nw,
                                input int e_fw, input int e_lw, input int e_dc);
        checks++;
        if (nw !== 91 || fw !== e_fw || lw !== e_lw || dc !== e_dc || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: writes=%0d first=%0d last=%0d done=%0d left=%0d, want 91 %0d %0d %0d 0",
                     nm, nw, fw, lw, dc, exp_q.size(), e_fw, e_lw, e_dc);
        end
    endtask

    task automatic check_rec(input string nm, input int base, input logic [55:0] want);
        logic [55:0] w;
        w = want;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap[base + i] !== w[55 - 8*i -: 8]) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h", nm, i, cap[base + i], w[55 - 8*i -: 8]);
            end
        end
    endtask

    task automatic idle_check(input string nm, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || wr_uart !== 1'b0) begin
                errors++;
                $display("FAIL %s cyc%0d: busy=%b done=%b wr=%b, want 0 0 0", nm, i, busy, done, wr_uart);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tx_full = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 12'((i << 8) | i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ch_addr !== '0 || wr_uart !== 1'b0 || w_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: addr=%h wr=%b wd=%h busy=%b done=%b, want 0 0 00 0 0",
                     ch_addr, wr_uart, w_data, busy, done);
        end
        @(posedge clk); #1; rst = 1'b0;
        idle_check("reset_idle", 20);
    endtask

    task automatic test_single_frame;
        int fw, lw, dc, nw;
        for (int i = 0; i < 16; i++) mem[i] = 12'((i << 8) | i);
        run_frame(-1, 0, -1, -1, -1, fw, lw, dc, nw);
        check_timing("single_frame", fw, lw, dc, nw, 3, 117, 118);
        check_rec("ch12_rec", 84, {8'h43, 8'h3A, 8'h43, 8'h30, 8'h43, 8'h0D, 8'h0A});
        check_rec("ch3_rec", 21, {8'h33, 8'h3A, 8'h33, 8'h30, 8'h33, 8'h0D, 8'h0A});
    endtask

    task automatic test_hex_edges;
        int fw, lw, dc, nw;
        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
        mem[0] = 12'h000; mem[1] = 12'hFFF; mem[2] = 12'hA09;
        run_frame(-1, 0, -1, -1, -1, fw, lw, dc, nw);
        check_timing("hex_frame", fw, lw, dc, nw, 3, 117, 118);
        check_rec("rec0", 0,  {8'h30, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A});
        check_rec("rec1", 7,  {8'h31, 8'h3A, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A});
        check_rec("rec2", 14, {8'h32, 8'h3A, 8'h41, 8'h30, 8'h39, 8'h0D, 8'h0A});
    endtask

    task automatic test_backpressure;
        int fw, lw, dc, nw;
        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
        run_frame(4*7 + 2, 5, -1, -1, -1, fw, lw, dc, nw);
        check_timing("backpressure", fw, lw, dc, nw, 3, 122, 123);
    endtask

    task automatic test_start_ignore;
        int fw, lw, dc, nw;
        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
        run_frame(-1, 0, 10, 118, -1, fw, lw, dc, nw);
        check_timing("start_busy_ignored", fw, lw, dc, nw, 3, 117, 118);
        idle_check("no_second_frame", 10);
        run_frame(-1, 0, -1, -1, -1, fw, lw, dc, nw);
        check_timing("frame_pre_119", fw, lw, dc, nw, 3, 117, 118);
        run_frame(-1, 0, -1, -1, -1, fw, lw, dc, nw);
        check_timing("start_at_119", fw, lw, dc, nw, 3, 117, 118);
    endtask

    task automatic test_mid_reset;
        int fw, lw, dc, nw;
        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
        run_frame(-1, 0, -1, -1, 50, fw, lw, dc, nw);
        checks++;
        if (dc !== -1) begin
            errors++;
            $display("FAIL abort_done: got done at %0d, want none", dc);
        end
        @(posedge clk); #1; rst = 1'b0;
        idle_check("post_reset_idle", 5);
        run_frame(-1, 0, -1, -1, -1, fw, lw, dc, nw);
        check_timing("after_reset_frame", fw, lw, dc, nw, 3, 117, 118);
        checks++;
        if (cap[0] !== 8'h30) begin
            errors++;
            $display("FAIL first_byte: got %h want 30", cap[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_hex_edges();
        test_backpressure();
        test_start_ignore();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
